// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM encoding and grant type for the RAM access controller.
// Valid RAM addresses are 0..MEMDEPTH-1; everything above is rejected with an error ack.
package InstructionStruct;

    localparam int DWIDTH   = 8;
    localparam int AWIDTH   = 4;
    localparam int MEMDEPTH = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        ACK  = 2'd3
    } mem_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

    // Zero-extend by one bit so MEMDEPTH == 2**AWIDTH still compares correctly.
    function automatic logic addr_in_range(input logic [AWIDTH-1:0] addr);
        return ({1'b0, addr} < (AWIDTH + 1)'(MEMDEPTH));
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb.sv
// Two-way round-robin arbiter between instruction fetch and data memory.
// Purely combinational; the last-grant history register lives in the controller.
module mem_rr_arb
    import InstructionStruct::*;
(
    input  logic   if_req,
    input  logic   dm_req,
    input  grant_t last_grant,
    output grant_t grant
);

    always_comb begin
        grant = GNT_IF;
        if (if_req && dm_req) begin
            grant = (last_grant == GNT_IF) ? GNT_DM : GNT_IF;
        end else if (dm_req) begin
            grant = GNT_DM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM controller shared by the fetch and data-memory ports.
// One access in flight at a time; the tri-state bus is driven only while writing.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the winning access
// RD    | ram_rdEn high, bus released; RAM data captured on the closing edge
// WR    | ram_wrEn high, bus driven with latched store data
// ACK   | one-cycle ack (and err) pulse to the granted port
module mem_arbiter
    import InstructionStruct::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [AWIDTH-1:0] if_addr,
    output logic [DWIDTH-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [AWIDTH-1:0] dm_addr,
    input  logic [DWIDTH-1:0] dm_wdata,
    output logic [DWIDTH-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              dm_err,
    inout  wire  [DWIDTH-1:0] ram_data,
    output logic [AWIDTH-1:0] ram_addr,
    output logic              ram_rdEn,
    output logic              ram_wrEn
);

    logic              r_rst_meta;
    logic              r_rst_sync;
    logic              w_rst_n;

    mem_state_t        r_state;
    grant_t            r_gnt;
    grant_t            r_last_grant;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic              r_rd_en;
    logic              r_wr_en;
    logic              r_if_ack;
    logic              r_if_err;
    logic              r_dm_ack;
    logic              r_dm_err;
    logic [DWIDTH-1:0] r_if_rdata;
    logic [DWIDTH-1:0] r_dm_rdata;

    grant_t            w_grant;
    logic [AWIDTH-1:0] w_sel_addr;
    logic              w_sel_we;
    logic              w_sel_ok;

    // Assertion is immediate; release is delayed two edges to avoid metastability.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst_n = r_rst_sync;

    mem_rr_arb u_rr_arb (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    assign w_sel_addr = (w_grant == GNT_IF) ? if_addr : dm_addr;
    assign w_sel_we   = (w_grant == GNT_DM) && dm_we;
    assign w_sel_ok   = addr_in_range(w_sel_addr);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= IDLE;
            r_gnt        <= GNT_IF;
            r_last_grant <= GNT_IF;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_if_ack     <= 1'b0;
            r_if_err     <= 1'b0;
            r_dm_ack     <= 1'b0;
            r_dm_err     <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_if_err <= 1'b0;
            r_dm_ack <= 1'b0;
            r_dm_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        r_gnt        <= w_grant;
                        r_last_grant <= w_grant;
                        r_wdata      <= dm_wdata;
                        if (!w_sel_ok) begin
                            // Rejected access: ram_addr keeps its old value, no enable rises.
                            r_state <= ACK;
                            if (w_grant == GNT_IF) begin
                                r_if_ack <= 1'b1;
                                r_if_err <= 1'b1;
                            end else begin
                                r_dm_ack <= 1'b1;
                                r_dm_err <= 1'b1;
                            end
                        end else begin
                            r_addr <= w_sel_addr;
                            if (w_sel_we) begin
                                r_state <= WR;
                                r_wr_en <= 1'b1;
                            end else begin
                                r_state <= RD;
                                r_rd_en <= 1'b1;
                            end
                        end
                    end
                end

                RD: begin
                    r_rd_en <= 1'b0;
                    r_state <= ACK;
                    if (r_gnt == GNT_IF) begin
                        r_if_rdata <= ram_data;
                        r_if_ack   <= 1'b1;
                    end else begin
                        r_dm_rdata <= ram_data;
                        r_dm_ack   <= 1'b1;
                    end
                end

                WR: begin
                    r_wr_en  <= 1'b0;
                    r_state  <= ACK;
                    r_dm_ack <= 1'b1;
                end

                ACK: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                    r_rd_en <= 1'b0;
                    r_wr_en <= 1'b0;
                end
            endcase
        end
    end

    // Gated by state alone so an async reset releases the bus immediately.
    assign ram_data = (r_state == WR) ? r_wdata : {DWIDTH{1'bz}};

    assign ram_addr = r_addr;
    assign ram_rdEn = r_rd_en;
    assign ram_wrEn = r_wr_en;
    assign if_rdata = r_if_rdata;
    assign if_ack   = r_if_ack;
    assign if_err   = r_if_err;
    assign dm_rdata = r_dm_rdata;
    assign dm_ack   = r_dm_ack;
    assign dm_err   = r_dm_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: port drivers push expected acks, a monitor pops and compares.
// Includes a simple asynchronous-read RAM model and a pulled-down bus to observe release.
module tb_mem_arbiter;
    import InstructionStruct::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [AWIDTH-1:0] if_addr;
    logic [DWIDTH-1:0] if_rdata;
    logic              if_ack;
    logic              if_err;
    logic              dm_req;
    logic              dm_we;
    logic [AWIDTH-1:0] dm_addr;
    logic [DWIDTH-1:0] dm_wdata;
    logic [DWIDTH-1:0] dm_rdata;
    logic              dm_ack;
    logic              dm_err;
    wire  [DWIDTH-1:0] ram_data;
    logic [AWIDTH-1:0] ram_addr;
    logic              ram_rdEn;
    logic              ram_wrEn;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .if_err   (if_err),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ack   (dm_ack),
        .dm_err   (dm_err),
        .ram_data (ram_data),
        .ram_addr (ram_addr),
        .ram_rdEn (ram_rdEn),
        .ram_wrEn (ram_wrEn)
    );

    // RAM model: async read, write on posedge, preset contents 0x10+i.
    logic [DWIDTH-1:0] ram_mem [0:15];
    logic ram_loaded = 1'b0;
    assign ram_data = ram_rdEn ? ram_mem[ram_addr] : {DWIDTH{1'bz}};
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= 8'h10 + 8'(i);
            ram_loaded <= 1'b1;
        end else if (ram_wrEn) begin
            ram_mem[ram_addr] <= ram_data;
        end
    end

    for (genvar g = 0; g < DWIDTH; g++) begin : g_pd
        pulldown pd_i (ram_data[g]);
    end

    typedef struct {
        logic              err;
        logic [DWIDTH-1:0] data;
        int                ack_at;
    } exp_t;

    exp_t if_q[$];
    exp_t dm_q[$];
    exp_t if_e;
    exp_t dm_e;
    logic [DWIDTH-1:0] shadow [0:15];
    logic [DWIDTH-1:0] exp_if_rdata = '0;
    logic [DWIDTH-1:0] exp_dm_rdata = '0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (if_ack) begin
            if (if_q.size() == 0) begin
                total++; bad++;
                $display("FAIL if_unexpected_ack: got ack expected none (cyc=%0d)", cyc);
            end else begin
                if_e = if_q.pop_front();
                chk("if_err", int'(if_err), int'(if_e.err));
                chk("if_rdata", int'(if_rdata), int'(if_e.data));
                if (if_e.ack_at >= 0) chk("if_ack_cycle", cyc, if_e.ack_at);
            end
        end
        if (dm_ack) begin
            if (dm_q.size() == 0) begin
                total++; bad++;
                $display("FAIL dm_unexpected_ack: got ack expected none (cyc=%0d)", cyc);
            end else begin
                dm_e = dm_q.pop_front();
                chk("dm_err", int'(dm_err), int'(dm_e.err));
                chk("dm_rdata", int'(dm_rdata), int'(dm_e.data));
                if (dm_e.ack_at >= 0) chk("dm_ack_cycle", cyc, dm_e.ack_at);
            end
        end
        if (reset) begin
            chk("bus_rd_wr_exclusive", int'(ram_rdEn && ram_wrEn), 0);
            if (!ram_rdEn && !ram_wrEn) chk("bus_released", int'(ram_data), 0);
        end
        if (ram_wrEn) wr_cnt++;
        if (ram_rdEn) rd_cnt++;
    end

    task automatic if_access(input logic [AWIDTH-1:0] a, input int ack_at);
        exp_t e;
        bit   got = 0;
        if (int'(a) >= MEMDEPTH) begin
            e.err = 1'b1; e.data = exp_if_rdata;
        end else begin
            e.err = 1'b0; e.data = shadow[a]; exp_if_rdata = shadow[a];
        end
        e.ack_at = ack_at;
        if_q.push_back(e);
        if_addr = a;
        if_req  = 1'b1;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (if_ack) got = 1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL if_timeout: got no ack expected ack for addr %0d", a);
        end
        if_req = 1'b0;
    endtask

    task automatic dm_access(input logic we, input logic [AWIDTH-1:0] a,
                             input logic [DWIDTH-1:0] wd, input int ack_at);
        exp_t e;
        bit   got = 0;
        if (int'(a) >= MEMDEPTH) begin
            e.err = 1'b1; e.data = exp_dm_rdata;
        end else if (we) begin
            shadow[a] = wd; e.err = 1'b0; e.data = exp_dm_rdata;
        end else begin
            e.err = 1'b0; e.data = shadow[a]; exp_dm_rdata = shadow[a];
        end
        e.ack_at = ack_at;
        dm_q.push_back(e);
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        dm_req   = 1'b1;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (dm_ack) got = 1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL dm_timeout: got no ack expected ack for addr %0d", a);
        end
        dm_req = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_if_ack"},   int'(if_ack), 0);
        chk({nm, "_dm_ack"},   int'(dm_ack), 0);
        chk({nm, "_if_err"},   int'(if_err), 0);
        chk({nm, "_dm_err"},   int'(dm_err), 0);
        chk({nm, "_rdEn"},     int'(ram_rdEn), 0);
        chk({nm, "_wrEn"},     int'(ram_wrEn), 0);
        chk({nm, "_ram_addr"}, int'(ram_addr), 0);
        chk({nm, "_if_rdata"}, int'(if_rdata), 0);
        chk({nm, "_dm_rdata"}, int'(dm_rdata), 0);
        chk({nm, "_bus"},      int'(ram_data), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500us");
        $fatal(1);
    end

    initial begin
        int c0;
        int w0;
        int r0;
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        for (int i = 0; i < 16; i++) shadow[i] = 8'h10 + 8'(i);
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // First tie after reset goes to data; then grants alternate IF, DM, IF.
        c0 = cyc;
        fork
            begin
                dm_access(1'b0, 4'd2, 8'h00, c0 + 2);
                dm_access(1'b0, 4'd0, 8'h00, c0 + 8);
            end
            begin
                if_access(4'd1, c0 + 5);
                if_access(4'd3, c0 + 11);
            end
        join
        chk("tie_if_rdata", int'(if_rdata), 'h13);
        chk("tie_dm_rdata", int'(dm_rdata), 'h10);

        // Store 0xA5 to 5, then load it back.
        repeat (2) @(negedge clk);
        w0 = wr_cnt;
        dm_access(1'b1, 4'd5, 8'hA5, cyc + 2);
        chk("store_wrEn_cycles", wr_cnt - w0, 1);
        repeat (2) @(negedge clk);
        dm_access(1'b0, 4'd5, 8'h00, cyc + 2);
        chk("load5_value", int'(dm_rdata), 'hA5);
        chk("load5_err", int'(dm_err), 0);

        // Out-of-range fetch: error ack one cycle after acceptance, RAM untouched.
        repeat (2) @(negedge clk);
        w0 = wr_cnt; r0 = rd_cnt;
        if_access(4'(MEMDEPTH), cyc + 1);
        chk("oor_no_wrEn", wr_cnt - w0, 0);
        chk("oor_no_rdEn", rd_cnt - r0, 0);
        chk("oor_if_rdata_hold", int'(if_rdata), 'h13);
        repeat (2) @(negedge clk);
        dm_access(1'b0, 4'd15, 8'h00, cyc + 1);
        chk("oor_dm_rdata_hold", int'(dm_rdata), 'hA5);

        // Mixed traffic: fetches read 0..3 (never stored), data port owns 4..15.
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    if_access(($urandom_range(0, 9) == 0) ? 4'(12 + $urandom_range(0, 3))
                                                          : 4'($urandom_range(0, 3)), -1);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 500; i++) begin
                    dm_access(1'($urandom_range(0, 1)), 4'($urandom_range(4, 15)),
                              8'($urandom_range(0, 255)), -1);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join
        repeat (3) @(negedge clk);
        chk("if_q_drained", if_q.size(), 0);
        chk("dm_q_drained", dm_q.size(), 0);

        // Reset asserted in the middle of a store: no write, bus released at once.
        dm_we = 1'b1; dm_addr = 4'd6; dm_wdata = (shadow[6] ^ 8'hFF); dm_req = 1'b1;
        @(posedge clk);
        #2;
        chk("mid_store_in_wr", int'(ram_wrEn), 1);
        reset = 1'b0;
        #1;
        chk("mid_store_wrEn_drop", int'(ram_wrEn), 0);
        chk("mid_store_bus_release", int'(ram_data), 0);
        dm_req = 1'b0;
        @(negedge clk);
        chk_outputs_zero("mid_rst_a");
        @(negedge clk);
        chk_outputs_zero("mid_rst_b");
        chk("mid_store_mem6", int'(ram_mem[6]), int'(shadow[6]));
        reset = 1'b1;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
        repeat (4) @(negedge clk);
        dm_access(1'b0, 4'd6, 8'h00, cyc + 2);
        repeat (3) @(negedge clk);
        chk("dm_q_final", dm_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
